// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg: constants and types shared by the program loader files.
//   CODE_W / ADDR_W / DEPTH : instruction word width, RAM address width, words per load.
//   BYTES_PER_WORD          : stream bytes per instruction word (7 + 8 + 8 bits).
//   state_t                 : loader FSM states built on 3-bit encodings.
// Optional feature macro: PROG_LOADER_CHECKSUM_EN (enables the CHK state in prog_loader).
package prog_loader_pkg;

  localparam int CODE_W         = 23;
  localparam int ADDR_W         = 5;
  localparam int DEPTH          = 32;
  localparam int BYTES_PER_WORD = 3;

  // DEPTH as a byte, for range-checking the word count byte without width mixing.
  localparam logic [7:0]        DEPTH_B  = 8'(DEPTH);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  localparam logic [2:0] ENC_IDLE  = 3'd0;
  localparam logic [2:0] ENC_COUNT = 3'd1;
  localparam logic [2:0] ENC_B0    = 3'd2;
  localparam logic [2:0] ENC_B1    = 3'd3;
  localparam logic [2:0] ENC_B2    = 3'd4;
  localparam logic [2:0] ENC_CHK   = 3'd5;
  localparam logic [2:0] ENC_DONE  = 3'd6;
  localparam logic [2:0] ENC_ERR   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = ENC_IDLE,
    ST_COUNT = ENC_COUNT,
    ST_B0    = ENC_B0,
    ST_B1    = ENC_B1,
    ST_B2    = ENC_B2,
    ST_CHK   = ENC_CHK,
    ST_DONE  = ENC_DONE,
    ST_ERR   = ENC_ERR
  } state_t;

  // States in which the loader is consuming stream bytes.
  function automatic logic is_load_state(state_t s);
    return (s == ST_COUNT) || (s == ST_B0) || (s == ST_B1) ||
           (s == ST_B2) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if: byte stream and program RAM write bus of the loader.
//   in_data/in_valid/in_ready : byte stream. A byte transfers on a rising edge where
//                               in_valid & in_ready are both high; the source holds
//                               in_data/in_valid stable until that happens, and the
//                               sink may accept a byte on every cycle.
//   wr_en/wr_addr/wr_data     : one-cycle program RAM write strobe, address and word.
// modport master : loader side (sinks the stream, drives the RAM write bus).
// modport slave  : environment side (sources the stream, observes writes).
interface prog_loader_if;
  import prog_loader_pkg::*;

  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [CODE_W-1:0] wr_data;

  modport master (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/prog_word_packer.sv
// prog_word_packer: assembles one instruction word from three stream bytes.
//   clk, rst : clock, synchronous active-high reset
//   ld_hi    : B0 byte accepted; its low 7 bits become word[22:16]
//   ld_mid   : B1 byte accepted; it becomes word[15:8]
//   in_byte  : current stream byte
//   word     : {hi, mid, in_byte}; valid as the full word while the B2 byte is presented
//   b0_bad   : bit 7 of in_byte, which must be clear for a B0 byte
module prog_word_packer
  import prog_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_hi,
  input  logic              ld_mid,
  input  logic [7:0]        in_byte,
  output logic [CODE_W-1:0] word,
  output logic              b0_bad
);

  logic [6:0] hi_q, hi_d;
  logic [7:0] mid_q, mid_d;

  always_comb begin
    hi_d  = hi_q;
    mid_d = mid_q;
    if (ld_hi)  hi_d  = in_byte[6:0];
    if (ld_mid) mid_d = in_byte;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q  <= '0;
      mid_q <= '0;
    end else begin
      hi_q  <= hi_d;
      mid_q <= mid_d;
    end
  end

  // The low byte is taken straight from the stream so the word can be
  // registered into the write port on the B2 handshake edge itself.
  assign word   = {hi_q, mid_q, in_byte};
  assign b0_bad = in_byte[7];

endmodule

// File: rtl/prog_loader.sv
// prog_loader: writer side of the instruction memory. Takes a byte stream
// (count byte N, then N words of 3 bytes each), writes the words to program
// RAM at addresses 0..N-1 and holds the processor in reset until the load
// completes successfully.
//   clk, rst   : clock, synchronous active-high reset
//   start      : one-cycle pulse; starts a load from IDLE, DONE or ERR
//   bus        : prog_loader_if.master (byte stream in, RAM write port out)
//   cpu_rst    : processor reset, low only in DONE
//   busy       : loading (COUNT/B0/B1/B2/CHK)
//   done / err : load finished / load rejected (sticky until start or rst)
//   dbg_state  : current FSM state
// Optional feature macro: PROG_LOADER_CHECKSUM_EN. When defined, one checksum
// byte follows the last word and must equal the XOR of every accepted byte
// from N through the last word byte.
module prog_loader
  import prog_loader_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  prog_loader_if.master bus,
  output logic          cpu_rst,
  output logic          busy,
  output logic          done,
  output logic          err,
  output state_t        dbg_state
);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] word_idx_q, word_idx_d;
  logic [ADDR_W-1:0] last_idx_q, last_idx_d;   // N-1
  logic              in_ready_q, in_ready_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [CODE_W-1:0] wr_data_q, wr_data_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  logic              hs;
  logic              ld_hi, ld_mid;
  logic [CODE_W-1:0] packed_word;
  logic              b0_bad;

  assign hs     = bus.in_valid & in_ready_q;
  assign ld_hi  = hs && (state_q == ST_B0);
  assign ld_mid = hs && (state_q == ST_B1);

  prog_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .ld_hi   (ld_hi),
    .ld_mid  (ld_mid),
    .in_byte (bus.in_data),
    .word    (packed_word),
    .b0_bad  (b0_bad)
  );

  always_comb begin
    state_d    = state_q;
    word_idx_d = word_idx_q;
    last_idx_d = last_idx_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_COUNT;
          word_idx_d = '0;
          wr_addr_d  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end

      ST_COUNT: begin
        if (hs) begin
          // N = DEPTH maps to last index DEPTH-1 through the low ADDR_W bits.
          last_idx_d = bus.in_data[ADDR_W-1:0] - ADDR_ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d     = bus.in_data;
`endif
          if ((bus.in_data != 8'd0) && (bus.in_data <= DEPTH_B)) state_d = ST_B0;
          else                                                  state_d = ST_ERR;
        end
      end

      ST_B0: begin
        if (hs) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.in_data;
`endif
          state_d = b0_bad ? ST_ERR : ST_B1;
        end
      end

      ST_B1: begin
        if (hs) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ bus.in_data;
`endif
          state_d = ST_B2;
        end
      end

      ST_B2: begin
        if (hs) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d     = csum_q ^ bus.in_data;
`endif
          // Write is issued next cycle while the FSM already waits for the
          // next B0 byte, so the stream never stalls on a word boundary.
          wr_en_d    = 1'b1;
          wr_addr_d  = word_idx_q;
          wr_data_d  = packed_word;
          word_idx_d = word_idx_q + ADDR_ONE;
          if (word_idx_q == last_idx_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
            state_d = ST_CHK;
`else
            state_d = ST_DONE;
`endif
          end else begin
            state_d = ST_B0;
          end
        end
      end

`ifdef PROG_LOADER_CHECKSUM_EN
      ST_CHK: begin
        if (hs) state_d = (bus.in_data == csum_q) ? ST_DONE : ST_ERR;
      end
`endif

      default: state_d = ST_IDLE;
    endcase

    // Flags are registered copies of the next-state decode.
    in_ready_d = is_load_state(state_d);
    busy_d     = is_load_state(state_d);
    done_d     = (state_d == ST_DONE);
    err_d      = (state_d == ST_ERR);
    cpu_rst_d  = (state_d != ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      word_idx_q <= '0;
      last_idx_q <= '0;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_idx_q <= word_idx_d;
      last_idx_q <= last_idx_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign cpu_rst      = cpu_rst_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: self-checking bench for prog_loader (default build and
// PROG_LOADER_CHECKSUM_EN build). A stream-level model turns each byte list
// into the expected RAM writes, the number of bytes the loader must accept
// and the final outcome; a negedge monitor checks every write against that.
module tb_prog_loader;
  import prog_loader_pkg::*;

  typedef logic [7:0] bytes_t[$];

  localparam int ST_M_BUSY = 0;
  localparam int ST_M_DONE = 1;
  localparam int ST_M_ERR  = 2;

  logic   clk = 1'b0;
  logic   rst;
  logic   start;
  logic   cpu_rst, busy, done, err;
  state_t dbg_state;

  prog_loader_if bus();

  prog_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bus       (bus),
    .cpu_rst   (cpu_rst),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [ADDR_W+CODE_W-1:0] exp_q[$];
  logic [CODE_W-1:0]        ram[DEPTH];
  logic [CODE_W-1:0]        ram_snap[DEPTH];
  bit                       mon_en = 1'b0;
  int                       model_nacc;
  int                       model_status;
  logic [7:0]               model_xor;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      chk("ready_eq_busy", 32'(bus.in_ready), 32'(busy));
      chk("cpu_rst_eq_not_done", 32'(cpu_rst), 32'(!done));
      chk("flags_exclusive", 32'((int'(busy) + int'(done) + int'(err)) > 1), 32'd0);
      if (bus.wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write addr=%0d data=0x%0h expected=none", bus.wr_addr, bus.wr_data);
        end else begin
          logic [ADDR_W+CODE_W-1:0] e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(bus.wr_addr), 32'(e[ADDR_W+CODE_W-1:CODE_W]));
          chk("wr_data", 32'(bus.wr_data), 32'(e[CODE_W-1:0]));
        end
        ram[bus.wr_addr] = bus.wr_data;
      end
    end
  end

  // ---------------- behavioural model ----------------
  // Walks the byte list with the load rules: count byte, 3-byte words with a
  // clear top bit on the first byte, optional trailing XOR byte.
  task automatic model_load(input bytes_t b);
    logic [7:0]        n, v, x;
    logic [CODE_W-1:0] w;
    int                idx;
    w = '0;
    n = b[0];
    x = n;
    model_nacc = 1;
    model_status = ST_M_BUSY;
    if (n == 8'd0 || int'(n) > DEPTH) begin
      model_status = ST_M_ERR;
      model_xor = x;
      return;
    end
    for (int k = 0; k < int'(n); k++) begin
      for (int j = 0; j < BYTES_PER_WORD; j++) begin
        idx = 1 + BYTES_PER_WORD * k + j;
        if (idx >= b.size()) begin
          model_xor = x;
          return;
        end
        v = b[idx];
        model_nacc++;
        if (j == 0 && v[7]) begin
          model_status = ST_M_ERR;
          model_xor = x;
          return;
        end
        x = x ^ v;
        if (j == 0) w = {v[6:0], 16'h0000};
        else if (j == 1) w[15:8] = v;
        else begin
          w[7:0] = v;
          exp_q.push_back({k[ADDR_W-1:0], w});
        end
      end
    end
    model_xor = x;
`ifdef PROG_LOADER_CHECKSUM_EN
    idx = 1 + BYTES_PER_WORD * int'(n);
    if (idx >= b.size()) return;
    model_nacc++;
    model_status = (b[idx] == x) ? ST_M_DONE : ST_M_ERR;
`else
    model_status = ST_M_DONE;
`endif
  endtask

  // ---------------- driver tasks ----------------
  // All drivers are entered and left at #1 after a rising edge.
  task automatic send_byte(input logic [7:0] v, inout int stalls);
    int t;
    bus.in_data  = v;
    bus.in_valid = 1'b1;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 20) begin
      checks++;
      failures++;
      $display("FAIL handshake_timeout in_ready=%b required=1", bus.in_ready);
    end else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    stalls += t;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
    chk({tag, "_wr_en"},    32'(bus.wr_en),    32'd0);
    chk({tag, "_wr_addr"},  32'(bus.wr_addr),  32'd0);
    chk({tag, "_wr_data"},  32'(bus.wr_data),  32'd0);
    chk({tag, "_cpu_rst"},  32'(cpu_rst),      32'd1);
    chk({tag, "_busy"},     32'(busy),         32'd0);
    chk({tag, "_done"},     32'(done),         32'd0);
    chk({tag, "_err"},      32'(err),          32'd0);
    chk({tag, "_state"},    32'(dbg_state),    32'(ST_IDLE));
  endtask

  // Full load: model, start, stream the accepted bytes, check the outcome.
  // start_at >= 0 pulses start after that many bytes (must be ignored).
  task automatic run_load(input bytes_t b, input bit gaps, input int start_at, input string tag);
    int stalls;
    stalls = 0;
    model_load(b);
    pulse_start();
    for (int i = 0; i < model_nacc; i++) begin
      if (i == start_at) begin
        pulse_start();
        chk({tag, "_start_ignored_busy"}, 32'(busy), 32'd1);
      end
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      send_byte(b[i], stalls);
    end
    if (!gaps) chk({tag, "_no_ready_gaps"}, 32'(stalls), 32'd0);
    chk({tag, "_done"},    32'(done),    32'(model_status == ST_M_DONE));
    chk({tag, "_err"},     32'(err),     32'(model_status == ST_M_ERR));
    chk({tag, "_busy"},    32'(busy),    32'(model_status == ST_M_BUSY));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(model_status != ST_M_DONE));
    if (model_status != ST_M_BUSY) begin
      repeat (2) begin @(posedge clk); #1; end
      chk({tag, "_writes_drained"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_flags_hold"}, 32'({done, err}), 32'({model_status == ST_M_DONE, model_status == ST_M_ERR}));
    end
  endtask

  task automatic build_stream(input int n, input int seed, output bytes_t b);
    logic [7:0] x;
    b = {};
    b.push_back(8'(n));
    x = 8'(n);
    for (int k = 0; k < n; k++) begin
      b.push_back(8'((k * 37 + seed) & 8'h7f));
      b.push_back(8'(k * 11 + seed));
      b.push_back(8'(~(k + seed)));
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    foreach (b[i]) if (i > 0) x = x ^ b[i];
    b.push_back(x);
`endif
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bytes_t b;
    rst = 1'b1;
    start = 1'b0;
    bus.in_data = 8'h00;
    bus.in_valid = 1'b0;
    foreach (ram[i]) ram[i] = '0;

    // 1. reset
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    mon_en = 1'b1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_values("idle");

    // 2. two-word load with literal expectations
    b = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h01};
`ifdef PROG_LOADER_CHECKSUM_EN
    b.push_back(8'h73);
`endif
    run_load(b, 1'b0, -1, "two_words");
    chk("two_words_ram0", 32'(ram[0]), 32'h0012_3456);
    chk("two_words_ram1", 32'(ram[1]), 32'h0000_0001);
`ifdef PROG_LOADER_CHECKSUM_EN
    chk("model_nacc_two_words", 32'(model_nacc), 32'd8);
    chk("model_xor_two_words", 32'(model_xor), 32'h73);
`else
    chk("model_nacc_two_words", 32'(model_nacc), 32'd7);
`endif

    // 3. full-depth load, back-to-back then with random valid gaps
    build_stream(32, 5, b);
    run_load(b, 1'b0, -1, "full_b2b");
    chk("full_b2b_last_addr", 32'(bus.wr_addr), 32'd31);
    foreach (ram[i]) begin ram_snap[i] = ram[i]; ram[i] = '0; end
    run_load(b, 1'b1, -1, "full_gaps");
    foreach (ram[i]) chk("full_gaps_same_ram", 32'(ram[i]), 32'(ram_snap[i]));

    // 4. rejected loads
    b = '{8'h00, 8'h01, 8'h02, 8'h03};
    run_load(b, 1'b0, -1, "n_zero");
    b = '{8'h21, 8'h01, 8'h02, 8'h03};
    run_load(b, 1'b0, -1, "n_too_big");
    b = '{8'h02, 8'h80, 8'h02, 8'h03};
    run_load(b, 1'b0, -1, "b0_bit7");
    chk("b0_bit7_model_nacc", 32'(model_nacc), 32'd2);

    // 5. reset after B1 of word 3, then a clean reload with an ignored start
    build_stream(5, 9, b);
    b = b[0:11];
    run_load(b, 1'b0, -1, "mid_reset");
    chk("mid_reset_state_b2", 32'(dbg_state), 32'(ST_B2));
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_values("after_mid_reset");
    repeat (3) begin @(posedge clk); #1; end
    chk("mid_reset_no_writes", 32'(exp_q.size()), 32'd0);
    build_stream(5, 9, b);
    run_load(b, 1'b0, 4, "reload");

`ifdef PROG_LOADER_CHECKSUM_EN
    // 6. checksum: correct then corrupted (last word must still be written)
    build_stream(3, 20, b);
    run_load(b, 1'b0, -1, "cksum_ok");
    b[b.size()-1] = b[b.size()-1] ^ 8'h01;
    run_load(b, 1'b0, -1, "cksum_bad");
    chk("cksum_bad_last_addr", 32'(bus.wr_addr), 32'd2);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
